hack_mem_arbiter: RTL and testbench
===================================

Name: hack_mem_arbiter

Overview:
- Two-requester arbiter sharing one single-port word memory (RAM built from the DFlipFlop/register chain).
- Requester A is the CPU data port; requester B is the screen/IO scanner.
- Issues at most one access per cycle. Scheduling is round-robin with a bounded burst so neither side starves.
- Read data is returned one cycle after grant, tagged to the requester that issued the read.

Parameters:
- ADDR_W, 15, memory word-address width.
- DATA_W, 16, data word width.
- MAX_BURST, 4, max consecutive grants to one owner while the other side is requesting (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- a_req  in  1  A access request; held with a_we/a_addr/a_wdata stable until a_gnt.
- a_we  in  1  A write enable (1=write, 0=read).
- a_addr  in  ADDR_W  A word address.
- a_wdata  in  DATA_W  A write data.
- a_gnt  out  1  A access issued this cycle (combinational).
- a_rvalid  out  1  A read data valid (registered, 1 cycle after read grant).
- a_rdata  out  DATA_W  A read data; meaningful only when a_rvalid=1.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: identical to the A ports, for requester B.
- mem_en  out  1  memory access strobe = a_gnt | b_gnt.
- mem_we  out  1  selected we, gated by mem_en.
- mem_addr  out  ADDR_W  selected address; 0 when idle.
- mem_wdata  out  DATA_W  selected write data; 0 when idle.
- mem_rdata  in  DATA_W  memory read data, valid 1 cycle after mem_en with mem_we=0.

Behaviour:
- Reset (async assert, sync-safe release):
  - state=IDLE, burst_cnt=0, prio=A.
  - a_rvalid=b_rvalid=0.
  - All gnt/mem outputs 0, since no requests are decoded while rst_n=0.
- States: IDLE, OWN_A, OWN_B. burst_cnt counts consecutive grants to the current owner (saturating at MAX_BURST).
- IDLE:
  - Only one requester → grant it; go to OWN_<it>; burst_cnt=1.
  - Both requesters → grant prio side; go to OWN_<prio>; burst_cnt=1.
  - None → stay IDLE.
- OWN_X (Y = other side):
  - x_req & (!y_req | burst_cnt<MAX_BURST) → grant X; burst_cnt++.
  - Otherwise, if y_req → grant Y; go to OWN_Y; burst_cnt=1.
  - Otherwise → no grant; go to IDLE; burst_cnt=0.
- prio on every grant: set to the side NOT granted. Ties at the next IDLE therefore alternate.
- Grant rules:
  - At most one gnt per cycle; a_gnt & b_gnt is never 1.
  - gnt is never asserted without the matching req.
- Latency:
  - Write: completes at the grant edge; no rvalid.
  - Read: x_rvalid=1 exactly in the cycle after x_gnt with we=0. x_rdata = mem_rdata in that cycle.
  - Back-to-back reads give rvalid on consecutive cycles.
- Pipeline overlap: a read's rvalid cycle may coincide with a new grant to either side. The rvalid tag register prevents misrouting.
- Requester dropping req before grant: legal. No access is issued and no state corruption occurs.
- MAX_BURST=1: strict alternation whenever both requesters are active.
- Reset mid-read: pending rvalid is discarded and never asserted after release.

Decomposition:
- Shared package hack_pkg:
  - ADDR_W/DATA_W defaults.
  - State encoding constants ST_IDLE=2'd0, ST_OWN_A=2'd1, ST_OWN_B=2'd2.
  - Requester IDs REQ_A=1'b0, REQ_B=1'b1.
- One natural sub-module, hack_arb_fsm: state, burst_cnt, prio, grant decode.
- Top level holds the address/data muxing and the rvalid/tag register.

Test Plan:
- Reset then idle: rst_n=0 for 3 cycles → all outputs 0. Release with no req → mem_en=0, state stays IDLE.
- A-only read: a_req=1, a_we=0, a_addr=15'h0010, memory holds 16'hBEEF → a_gnt=1 at cycle 0 with mem_addr=15'h0010; a_rvalid=1, a_rdata=16'hBEEF at cycle 1; b_rvalid=0 throughout.
- Simultaneous requests after reset: a_req=b_req=1 (A write 16'h1234 @5, B read @5), held → A granted first (prio=A). With MAX_BURST=4 and both held, grant pattern is AAAABBBBAAAA; B reads 16'h1234.
- Burst release: A held, B asserted only for 1 cycle while A owns with burst_cnt=2 → B never granted. A keeps grant; no gnt asserted to B.
- Overlap: A read @7 (data 16'h00AA) granted cycle N, B write @9 granted cycle N+1 → at N+1 a_rvalid=1, a_rdata=16'h00AA, b_rvalid=0, mem_we=1, mem_addr=9.
- Reset mid-read: A read granted, rst_n pulsed low before the next edge → a_rvalid stays 0 after release; next A request is granted cleanly from IDLE.

Source files
------------

// File: rtl/hack_pkg.sv
// Shared types and constants for the two-requester Hack memory arbiter.
package hack_pkg;

  localparam int ADDR_W_DEF    = 15;
  localparam int DATA_W_DEF    = 16;
  localparam int MAX_BURST_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2
  } arb_state_e;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/hack_arb_fsm.sv
// Round-robin arbitration FSM with bounded burst: owner state, burst
// counter, tie-break priority and the combinational grant decode.
module hack_arb_fsm
  import hack_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF,
  localparam int CNT_W    = $clog2(MAX_BURST + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             a_req_i,
  input  logic             b_req_i,
  output logic             a_gnt_o,
  output logic             b_gnt_o,
  output arb_state_e       state_o,
  output logic [CNT_W-1:0] burst_cnt_o,
  output logic             prio_o
);

  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] BURST_ONE = CNT_W'(1);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] burst_q, burst_d;
  logic             prio_q, prio_d;
  logic             a_req, b_req;
  logic             a_gnt, b_gnt;
  logic [CNT_W-1:0] burst_inc;

  // Requests are masked while reset is held so no grant leaks out.
  assign a_req = a_req_i & rst_n_i;
  assign b_req = b_req_i & rst_n_i;

  assign burst_inc = (burst_q < BURST_MAX) ? burst_q + BURST_ONE : burst_q;

  always_comb begin
    a_gnt   = 1'b0;
    b_gnt   = 1'b0;
    state_d = state_q;
    burst_d = burst_q;
    prio_d  = prio_q;

    case (state_q)
      ST_IDLE: begin
        if (a_req && b_req) begin
          if (prio_q == REQ_A) a_gnt = 1'b1;
          else                 b_gnt = 1'b1;
        end else if (a_req) begin
          a_gnt = 1'b1;
        end else if (b_req) begin
          b_gnt = 1'b1;
        end
      end
      ST_OWN_A: begin
        if (a_req && (!b_req || (burst_q < BURST_MAX))) a_gnt = 1'b1;
        else if (b_req)                                 b_gnt = 1'b1;
      end
      ST_OWN_B: begin
        if (b_req && (!a_req || (burst_q < BURST_MAX))) b_gnt = 1'b1;
        else if (a_req)                                 a_gnt = 1'b1;
      end
      default: begin
      end
    endcase

    // A grant to the current owner extends its burst; a new owner restarts at 1.
    if (a_gnt) begin
      state_d = ST_OWN_A;
      burst_d = (state_q == ST_OWN_A) ? burst_inc : BURST_ONE;
      prio_d  = REQ_B;
    end else if (b_gnt) begin
      state_d = ST_OWN_B;
      burst_d = (state_q == ST_OWN_B) ? burst_inc : BURST_ONE;
      prio_d  = REQ_A;
    end else begin
      state_d = ST_IDLE;
      burst_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      burst_q <= '0;
      prio_q  <= REQ_A;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      prio_q  <= prio_d;
    end
  end

  assign a_gnt_o     = a_gnt;
  assign b_gnt_o     = b_gnt;
  assign state_o     = state_q;
  assign burst_cnt_o = burst_q;
  assign prio_o      = prio_q;

endmodule

// File: rtl/hack_mem_arbiter.sv
// Two-requester arbiter for a single-port word memory: request muxing onto
// the memory port and tagged one-cycle read-data return.
module hack_mem_arbiter
  import hack_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  // Handshake: a requester holds req/we/addr/wdata stable until its gnt is
  // seen high in a cycle; the access is issued at that cycle's rising edge.
  // A read returns x_rvalid for exactly one cycle, the cycle after the grant.
  arb_state_e       fsm_state;
  logic [CNT_W-1:0] fsm_burst_cnt;
  logic             fsm_prio;

  logic rd_valid_q, rd_valid_d;
  logic rd_tag_q, rd_tag_d;

  hack_arb_fsm #(
    .MAX_BURST (MAX_BURST)
  ) u_fsm (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .a_req_i     (a_req),
    .b_req_i     (b_req),
    .a_gnt_o     (a_gnt),
    .b_gnt_o     (b_gnt),
    .state_o     (fsm_state),
    .burst_cnt_o (fsm_burst_cnt),
    .prio_o      (fsm_prio)
  );

  always_comb begin
    mem_en    = a_gnt | b_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (a_gnt) begin
      mem_we    = a_we;
      mem_addr  = a_addr;
      mem_wdata = a_wdata;
    end else if (b_gnt) begin
      mem_we    = b_we;
      mem_addr  = b_addr;
      mem_wdata = b_wdata;
    end
  end

  // The tag remembers who issued the read so overlapping grants cannot misroute data.
  always_comb begin
    rd_valid_d = mem_en & ~mem_we;
    rd_tag_d   = rd_tag_q;
    if (mem_en) rd_tag_d = b_gnt ? REQ_B : REQ_A;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_tag_q   <= REQ_A;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_tag_q   <= rd_tag_d;
    end
  end

  assign a_rvalid = rd_valid_q & (rd_tag_q == REQ_A);
  assign b_rvalid = rd_valid_q & (rd_tag_q == REQ_B);
  assign a_rdata  = a_rvalid ? mem_rdata : '0;
  assign b_rdata  = b_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_hack_mem_arbiter.sv
// Directed self-checking bench for hack_mem_arbiter with a behavioural memory.
module tb_hack_mem_arbiter;
  import hack_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, a_we, b_req, b_we;
  logic [14:0] a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [15:0] a_rdata, b_rdata;
  logic        mem_en, mem_we;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;

  logic [15:0] mem [0:32767];
  logic [15:0] exp_q[$];
  int          total = 0;
  int          bad   = 0;

  hack_mem_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_req     (a_req),
    .a_we      (a_we),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .a_gnt     (a_gnt),
    .a_rvalid  (a_rvalid),
    .a_rdata   (a_rdata),
    .b_req     (b_req),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_gnt     (b_gnt),
    .b_rvalid  (b_rvalid),
    .b_rdata   (b_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // clock / memory model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 15'h0123; a_wdata = 16'h0;
    b_req = 1'b1; b_we = 1'b1; b_addr = 15'h0456; b_wdata = 16'h7777;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    total++; if (a_gnt !== 1'b0) begin bad++; $display("FAIL reset_a_gnt got=%b want=0", a_gnt); end
    total++; if (b_gnt !== 1'b0) begin bad++; $display("FAIL reset_b_gnt got=%b want=0", b_gnt); end
    total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL reset_mem_en got=%b want=0", mem_en); end
    total++; if (mem_addr !== 15'h0) begin bad++; $display("FAIL reset_mem_addr got=%h want=0", mem_addr); end
    total++; if (mem_wdata !== 16'h0) begin bad++; $display("FAIL reset_mem_wdata got=%h want=0", mem_wdata); end
    total++; if ({a_rvalid, b_rvalid} !== 2'b00) begin bad++; $display("FAIL reset_rvalid got=%b want=00", {a_rvalid, b_rvalid}); end
    a_req = 1'b0; b_req = 1'b0;
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk); #1;
      total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL idle_mem_en got=%b want=0", mem_en); end
      total++; if (dut.fsm_state !== ST_IDLE) begin bad++; $display("FAIL idle_state got=%0d want=%0d", dut.fsm_state, ST_IDLE); end
    end
  endtask

  task automatic test_a_read();
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b0; a_addr = 15'h0010;
    #1;
    total++; if ({a_gnt, b_gnt} !== 2'b10) begin bad++; $display("FAIL aread_gnt got=%b want=10", {a_gnt, b_gnt}); end
    total++; if (mem_addr !== 15'h0010) begin bad++; $display("FAIL aread_mem_addr got=%h want=0010", mem_addr); end
    total++; if ({mem_en, mem_we} !== 2'b10) begin bad++; $display("FAIL aread_mem_en_we got=%b want=10", {mem_en, mem_we}); end
    total++; if (b_rvalid !== 1'b0) begin bad++; $display("FAIL aread_b_rvalid0 got=%b want=0", b_rvalid); end
    @(negedge clk);
    a_req = 1'b0;
    #1;
    total++; if (a_rvalid !== 1'b1) begin bad++; $display("FAIL aread_rvalid got=%b want=1", a_rvalid); end
    total++; if (a_rdata !== 16'hBEEF) begin bad++; $display("FAIL aread_rdata got=%h want=BEEF", a_rdata); end
    total++; if (b_rvalid !== 1'b0) begin bad++; $display("FAIL aread_b_rvalid1 got=%b want=0", b_rvalid); end
    @(negedge clk); #1;
    total++; if (a_rvalid !== 1'b0) begin bad++; $display("FAIL aread_rvalid_drop got=%b want=0", a_rvalid); end
  endtask

  task automatic test_simultaneous();
    logic [11:0] pat;
    logic        prev_b;
    logic        exp_a;
    logic [15:0] want;
    pat    = 12'b1111_0000_1111;
    prev_b = 1'b0;
    apply_reset();
    a_req = 1'b1; a_we = 1'b1; a_addr = 15'd5; a_wdata = 16'h1234;
    b_req = 1'b1; b_we = 1'b0; b_addr = 15'd5; b_wdata = 16'h0;
    for (int i = 0; i < 12; i++) begin
      #1;
      exp_a = pat[11-i];
      total++; if ({a_gnt, b_gnt} !== {exp_a, ~exp_a}) begin bad++; $display("FAIL sim_gnt cyc=%0d got=%b want=%b", i, {a_gnt, b_gnt}, {exp_a, ~exp_a}); end
      total++; if (b_rvalid !== prev_b) begin bad++; $display("FAIL sim_b_rvalid cyc=%0d got=%b want=%b", i, b_rvalid, prev_b); end
      total++; if (a_rvalid !== 1'b0) begin bad++; $display("FAIL sim_a_rvalid cyc=%0d got=%b want=0", i, a_rvalid); end
      if (b_rvalid === 1'b1) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        total++; if (b_rdata !== want) begin bad++; $display("FAIL sim_b_rdata cyc=%0d got=%h want=%h", i, b_rdata, want); end
      end
      if (!exp_a) exp_q.push_back(16'h1234);
      prev_b = ~exp_a;
      @(negedge clk);
    end
    a_req = 1'b0; b_req = 1'b0;
    #1;
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sim_pending got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_burst_release();
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b1; a_addr = 15'h0020; a_wdata = 16'h5555;
    #1;
    total++; if (a_gnt !== 1'b1) begin bad++; $display("FAIL burst_g1 got=%b want=1", a_gnt); end
    @(negedge clk); #1;
    total++; if (a_gnt !== 1'b1) begin bad++; $display("FAIL burst_g2 got=%b want=1", a_gnt); end
    @(negedge clk);
    b_req = 1'b1; b_we = 1'b0; b_addr = 15'h0030;
    #1;
    total++; if (dut.fsm_burst_cnt !== 3'd2) begin bad++; $display("FAIL burst_cnt got=%0d want=2", dut.fsm_burst_cnt); end
    total++; if ({a_gnt, b_gnt} !== 2'b10) begin bad++; $display("FAIL burst_b_blip got=%b want=10", {a_gnt, b_gnt}); end
    @(negedge clk);
    b_req = 1'b0;
    repeat (3) begin
      #1;
      total++; if ({a_gnt, b_gnt} !== 2'b10) begin bad++; $display("FAIL burst_hold got=%b want=10", {a_gnt, b_gnt}); end
      total++; if (b_rvalid !== 1'b0) begin bad++; $display("FAIL burst_b_rvalid got=%b want=0", b_rvalid); end
      @(negedge clk);
    end
    a_req = 1'b0;
  endtask

  task automatic test_overlap();
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b0; a_addr = 15'd7;
    #1;
    total++; if (a_gnt !== 1'b1) begin bad++; $display("FAIL ovl_a_gnt got=%b want=1", a_gnt); end
    @(negedge clk);
    a_req = 1'b0;
    b_req = 1'b1; b_we = 1'b1; b_addr = 15'd9; b_wdata = 16'h0909;
    #1;
    total++; if ({a_gnt, b_gnt} !== 2'b01) begin bad++; $display("FAIL ovl_b_gnt got=%b want=01", {a_gnt, b_gnt}); end
    total++; if (a_rvalid !== 1'b1) begin bad++; $display("FAIL ovl_a_rvalid got=%b want=1", a_rvalid); end
    total++; if (a_rdata !== 16'h00AA) begin bad++; $display("FAIL ovl_a_rdata got=%h want=00AA", a_rdata); end
    total++; if (b_rvalid !== 1'b0) begin bad++; $display("FAIL ovl_b_rvalid got=%b want=0", b_rvalid); end
    total++; if ({mem_we, mem_addr} !== {1'b1, 15'd9}) begin bad++; $display("FAIL ovl_mem got=%b/%h want=1/0009", mem_we, mem_addr); end
    @(negedge clk);
    b_req = 1'b0;
    #1;
    total++; if ({a_rvalid, b_rvalid} !== 2'b00) begin bad++; $display("FAIL ovl_after_rvalid got=%b want=00", {a_rvalid, b_rvalid}); end
    total++; if (mem[9] !== 16'h0909) begin bad++; $display("FAIL ovl_write got=%h want=0909", mem[9]); end
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b0; a_addr = 15'h0010;
    #1;
    total++; if (a_gnt !== 1'b1) begin bad++; $display("FAIL mid_gnt got=%b want=1", a_gnt); end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    a_req = 1'b0;
    #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    total++; if (a_rvalid !== 1'b0) begin bad++; $display("FAIL mid_rvalid0 got=%b want=0", a_rvalid); end
    total++; if (dut.fsm_state !== ST_IDLE) begin bad++; $display("FAIL mid_state got=%0d want=%0d", dut.fsm_state, ST_IDLE); end
    @(negedge clk);
    a_req = 1'b1;
    #1;
    total++; if (a_rvalid !== 1'b0) begin bad++; $display("FAIL mid_rvalid1 got=%b want=0", a_rvalid); end
    total++; if ({a_gnt, mem_addr} !== {1'b1, 15'h0010}) begin bad++; $display("FAIL mid_regrant got=%b/%h want=1/0010", a_gnt, mem_addr); end
    @(negedge clk);
    a_req = 1'b0;
    #1;
    total++; if ({a_rvalid, a_rdata} !== {1'b1, 16'hBEEF}) begin bad++; $display("FAIL mid_read got=%b/%h want=1/BEEF", a_rvalid, a_rdata); end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'h0;
    mem[16] = 16'hBEEF;
    mem[7]  = 16'h00AA;
    test_reset();
    test_a_read();
    test_simultaneous();
    test_burst_release();
    test_overlap();
    test_reset_mid_read();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
